// File: rtl/neuron_writeback.sv
// neuron_writeback: accumulates MAC partial sums, converts to saturated Q8.8 (optional ReLU) and queues BRAM writes.
module neuron_writeback #(
    parameter int ACC_W      = 40,
    parameter int FRAC_SHIFT = 8,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        add_done,
    input  logic [31:0] partial_sum,
    input  logic        neuron_done,
    input  logic [15:0] out_addr,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        fifo_full,
    output logic        ovf_flag,
    output logic        drop_err,
    output logic [9:0]  neurons_written
);
    logic signed [ACC_W-1:0] acc, acc_next, shifted;
    logic        pos_sat, neg_sat;
    logic [15:0] sat_val, conv;
    logic        cap_valid;
    logic [15:0] cap_addr, cap_data;
    logic [15:0] mem_addr [2];
    logic [15:0] mem_data [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        pop, push, cap_load;

    always_comb begin
        acc_next = add_done ? acc + {{(ACC_W-32){partial_sum[31]}}, partial_sum} : acc;
        shifted  = acc_next >>> FRAC_SHIFT;
        pos_sat  = !shifted[ACC_W-1] && (|shifted[ACC_W-2:15]);
        neg_sat  = shifted[ACC_W-1] && !(&shifted[ACC_W-2:15]);
        sat_val  = pos_sat ? 16'h7fff : neg_sat ? 16'h8000 : shifted[15:0];
        conv     = (RELU_EN && sat_val[15]) ? 16'h0000 : sat_val;
        pop      = (count != 2'd0) && wr_ready;
        // a full queue still accepts the capture entry when the head leaves this cycle
        push     = cap_valid && ((count != 2'd2) || pop);
        cap_load = neuron_done && (!cap_valid || push);
        wr_en    = count != 2'd0;
        wr_addr  = wr_en ? mem_addr[rd_ptr] : 16'h0000;
        wr_data  = wr_en ? mem_data[rd_ptr] : 16'h0000;
        fifo_full = count == 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            cap_valid       <= 1'b0;
            cap_addr        <= '0;
            cap_data        <= '0;
            rd_ptr          <= 1'b0;
            wr_ptr          <= 1'b0;
            count           <= '0;
            ovf_flag        <= 1'b0;
            drop_err        <= 1'b0;
            neurons_written <= '0;
        end else begin
            acc <= neuron_done ? '0 : acc_next;
            if (neuron_done && (pos_sat || neg_sat))
                ovf_flag <= 1'b1;
            if (neuron_done && !cap_load)
                drop_err <= 1'b1;
            if (cap_load) begin
                cap_addr <= out_addr;
                cap_data <= conv;
            end
            cap_valid <= cap_load || (cap_valid && !push);
            if (push) begin
                mem_addr[wr_ptr] <= cap_addr;
                mem_data[wr_ptr] <= cap_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr          <= ~rd_ptr;
                neurons_written <= neurons_written + 10'd1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_neuron_writeback.sv
// tb_neuron_writeback: vector table plus stall/reset sequences, scoreboarded writes for ReLU on and off.
module tb_neuron_writeback;
    logic        clk = 1'b0;
    logic        rst, add_done, neuron_done, wr_ready;
    logic [31:0] partial_sum;
    logic [15:0] out_addr;
    logic        wr_en, fifo_full, ovf_flag, drop_err;
    logic [15:0] wr_addr, wr_data;
    logic [9:0]  neurons_written;
    logic        wr_en_nr, fifo_full_nr, ovf_nr, drop_nr;
    logic [15:0] wr_addr_nr, wr_data_nr;
    logic [9:0]  nw_nr;

    always #5 clk = ~clk;

    neuron_writeback dut (
        .clk(clk), .rst(rst), .add_done(add_done), .partial_sum(partial_sum),
        .neuron_done(neuron_done), .out_addr(out_addr), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fifo_full(fifo_full),
        .ovf_flag(ovf_flag), .drop_err(drop_err), .neurons_written(neurons_written)
    );

    neuron_writeback #(.RELU_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .add_done(add_done), .partial_sum(partial_sum),
        .neuron_done(neuron_done), .out_addr(out_addr), .wr_ready(wr_ready),
        .wr_en(wr_en_nr), .wr_addr(wr_addr_nr), .wr_data(wr_data_nr), .fifo_full(fifo_full_nr),
        .ovf_flag(ovf_nr), .drop_err(drop_nr), .neurons_written(nw_nr)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] data_nr;
    } exp_t;

    typedef struct {
        logic [31:0] ps [4];
        int          n;
        bit          same;
        logic [15:0] addr;
        logic [15:0] exp_d;
        logic [15:0] exp_nr;
        bit          ovf;
    } vec_t;

    exp_t q[$];
    vec_t vt[12];
    int   vectors = 0;
    int   miscompares = 0;
    int   nw_exp = 0;
    bit   ovf_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int b = 0;
        while (q.size() != 0 && b < 50) begin
            step;
            b++;
        end
        if (q.size() != 0)
            chk("drain timeout pending", 32'(q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected write: addr %h data %h, none expected", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_data relu off", 32'(wr_data_nr), 32'(e.data_nr));
                nw_exp++;
            end
        end
    end

    initial begin
        vt[0]  = '{'{32'h00010000, 32'h00020000, 32'h0, 32'h0}, 2, 1'b0, 16'h0040, 16'h0300, 16'h0300, 1'b0};
        vt[1]  = '{'{32'hFFFE0000, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0041, 16'h0000, 16'hFE00, 1'b0};
        vt[2]  = '{'{32'h007FFFFF, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0042, 16'h7FFF, 16'h7FFF, 1'b0};
        vt[3]  = '{'{32'hFF800000, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0043, 16'h0000, 16'h8000, 1'b0};
        vt[4]  = '{'{32'hFFFFFF80, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0044, 16'h0000, 16'hFFFF, 1'b0};
        vt[5]  = '{'{32'h0, 32'h0, 32'h0, 32'h0}, 0, 1'b0, 16'h0045, 16'h0000, 16'h0000, 1'b0};
        vt[6]  = '{'{32'h000012FF, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0046, 16'h0012, 16'h0012, 1'b0};
        vt[7]  = '{'{32'h00800000, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h0047, 16'h7FFF, 16'h7FFF, 1'b1};
        vt[8]  = '{'{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 4, 1'b0, 16'h0048, 16'h7FFF, 16'h7FFF, 1'b1};
        vt[9]  = '{'{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, 4, 1'b0, 16'h0049, 16'h0000, 16'h8000, 1'b1};
        vt[10] = '{'{32'h00010000, 32'h00050000, 32'h0, 32'h0}, 2, 1'b1, 16'h004A, 16'h0600, 16'h0600, 1'b0};
        vt[11] = '{'{32'h00000180, 32'h0, 32'h0, 32'h0}, 1, 1'b0, 16'h004B, 16'h0001, 16'h0001, 1'b0};

        rst = 1'b1; add_done = 1'b0; neuron_done = 1'b0; wr_ready = 1'b1;
        partial_sum = '0; out_addr = '0;
        step; step;
        rst = 1'b0;
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset fifo_full", 32'(fifo_full), 32'd0);
        chk("reset nw", 32'(neurons_written), 32'd0);
        chk("reset ovf", 32'(ovf_flag), 32'd0);
        chk("reset drop", 32'(drop_err), 32'd0);

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < vt[i].n - (vt[i].same ? 1 : 0); j++) begin
                add_done = 1'b1;
                partial_sum = vt[i].ps[j];
                step;
            end
            add_done = vt[i].same;
            partial_sum = vt[i].same ? vt[i].ps[vt[i].n-1] : 32'h0;
            neuron_done = 1'b1;
            out_addr = vt[i].addr;
            q.push_back('{vt[i].addr, vt[i].exp_d, vt[i].exp_nr});
            ovf_exp |= vt[i].ovf;
            step;
            add_done = 1'b0; neuron_done = 1'b0; partial_sum = '0;
            step;
            chk("wr_en at T+2", 32'(wr_en), 32'd1);
            chk("ovf_flag", 32'(ovf_flag), 32'(ovf_exp));
            chk("ovf_flag relu off", 32'(ovf_nr), 32'(ovf_exp));
            drain;
            chk("neurons_written", 32'(neurons_written), 32'(nw_exp));
        end
        chk("drop_err clear", 32'(drop_err), 32'd0);

        wr_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) chk("fifo_full after first", 32'(fifo_full), 32'd0);
            if (k == 3) chk("fifo_full after second", 32'(fifo_full), 32'd1);
            if (k == 4) chk("drop_err before fourth", 32'(drop_err), 32'd0);
            neuron_done = 1'b1;
            out_addr = 16'(k);
            if (k <= 3) q.push_back('{16'(k), 16'h0000, 16'h0000});
            step;
            neuron_done = 1'b0;
            step; step;
        end
        chk("drop_err set", 32'(drop_err), 32'd1);
        chk("drop_err relu off", 32'(drop_nr), 32'd1);
        chk("stalled wr_en", 32'(wr_en), 32'd1);
        chk("stalled head addr", 32'(wr_addr), 32'd1);
        chk("still full", 32'(fifo_full), 32'd1);
        wr_ready = 1'b1;
        drain;
        chk("nw after stall", 32'(neurons_written), 32'(nw_exp));
        chk("fifo empty after stall", 32'(wr_en), 32'd0);

        wr_ready = 1'b0;
        neuron_done = 1'b1; out_addr = 16'h0099;
        q.push_back('{16'h0099, 16'h0000, 16'h0000});
        step;
        neuron_done = 1'b0;
        step; step;
        add_done = 1'b1; partial_sum = 32'h00010000; step;
        partial_sum = 32'h00020000; step;
        rst = 1'b1; neuron_done = 1'b1; partial_sum = 32'h00040000;
        step;
        rst = 1'b0; add_done = 1'b0; neuron_done = 1'b0; partial_sum = '0;
        q.delete();
        nw_exp = 0; ovf_exp = 1'b0;
        chk("post-rst wr_en", 32'(wr_en), 32'd0);
        chk("post-rst wr_addr", 32'(wr_addr), 32'd0);
        chk("post-rst fifo_full", 32'(fifo_full), 32'd0);
        chk("post-rst nw", 32'(neurons_written), 32'd0);
        chk("post-rst ovf", 32'(ovf_flag), 32'd0);
        chk("post-rst drop", 32'(drop_err), 32'd0);
        wr_ready = 1'b1;
        step; step; step;
        neuron_done = 1'b1; out_addr = 16'h0050;
        q.push_back('{16'h0050, 16'h0000, 16'h0000});
        step;
        neuron_done = 1'b0;
        step;
        chk("post-rst wr_en at T+2", 32'(wr_en), 32'd1);
        drain;
        chk("post-rst nw one write", 32'(neurons_written), 32'(nw_exp));
        step; step;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/neuron_writeback.md
NEURON_WRITEBACK -- requirements
Module: neuron_writeback

Interface
REQ-001 Parameter ACC_W, 40, accumulator width in bits (signed); holds at least 64 full-scale partial sums.
REQ-002 Parameter FRAC_SHIFT, 8, arithmetic right shift from Q16.16 products to Q8.8 output.
REQ-003 Parameter RELU_EN, 1, 1 = clamp negative results to 0 before write.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 add_done  in  1  one-cycle pulse; partial_sum valid this cycle.
REQ-007 partial_sum  in  32  signed Q16.16 adder-tree sum of one 16-wide MAC pass.
REQ-008 neuron_done  in  1  one-cycle pulse; current neuron complete.
REQ-009 out_addr  in  16  BRAM destination address, sampled when neuron_done=1.
REQ-010 wr_ready  in  1  BRAM port accepts write this cycle.
REQ-011 wr_en  out  1  write request (valid).
REQ-012 wr_addr  out  16  write address.
REQ-013 wr_data  out  16  signed Q8.8 activation.
REQ-014 fifo_full  out  1  write queue holds 2 entries (stall hint upstream).
REQ-015 ovf_flag  out  1  sticky; a result saturated.
REQ-016 drop_err  out  1  sticky; a neuron result was lost.
REQ-017 neurons_written  out  10  count of completed writes, wraps 1023->0.

Function
REQ-018 On add_done, acc SHALL become acc + sign-extended partial_sum.
REQ-019 On neuron_done, final sum SHALL be acc_next (includes a same-cycle add_done); acc SHALL clear to 0 that cycle.
REQ-020 neuron_done without any prior add_done SHALL produce result 0x0000.
REQ-021 Conversion: arithmetic shift right by FRAC_SHIFT (floor), saturate to [-32768, 32767]; saturation SHALL set ovf_flag.
REQ-022 If RELU_EN=1, negative saturated values SHALL become 0x0000; ovf_flag still set on negative saturation.
REQ-023 Conversion result and out_addr SHALL register into a capture stage on the cycle after neuron_done (stage 1).
REQ-024 Capture stage SHALL enqueue into a 2-entry in-order FIFO the following cycle when FIFO not full; otherwise it holds.
REQ-025 wr_en SHALL equal FIFO non-empty; wr_addr/wr_data SHALL present the head entry and stay stable while wr_en=1 and wr_ready=0.
REQ-026 Pop occurs on wr_en && wr_ready; simultaneous pop and enqueue on a full FIFO SHALL succeed without loss.
REQ-027 Latency: neuron_done at cycle T, empty FIFO, wr_ready=1 -> wr_en=1 at T+2, popped at T+2.
REQ-028 neuron_done while capture stage occupied and unable to advance SHALL discard the new result, set drop_err, and still clear acc.
REQ-029 neurons_written SHALL increment by 1 on each pop.
REQ-030 fifo_full SHALL be 1 exactly when FIFO count = 2.
REQ-031 add_done and neuron_done SHALL be ignored during the rst cycle.

Reset
REQ-032 rst=1 SHALL clear acc, capture stage, FIFO, neurons_written, ovf_flag, drop_err; outputs wr_en=0, wr_addr=0, wr_data=0, fifo_full=0.
REQ-033 rst asserted mid-accumulation or with queued writes SHALL discard all pending data; no write follows reset.

Verification
REQ-034 add_done 0x00010000, add_done 0x00020000, neuron_done with out_addr=0x0040, wr_ready=1 -> wr_en at T+2, wr_addr=0x0040, wr_data=0x0300, neurons_written=1.
REQ-035 Single add_done 0xFFFE0000 then neuron_done -> wr_data=0x0000 (RELU_EN=1); wr_data=0xFE00 (RELU_EN=0).
REQ-036 Four add_done 0x7FFFFFFF then neuron_done -> wr_data=0x7FFF, ovf_flag=1 and remains 1 afterwards.
REQ-037 wr_ready=0, four neuron_done (addr 1,2,3,4, spaced 3 cycles) -> fifo_full=1 after second, third held in capture stage, fourth dropped, drop_err=1; wr_ready=1 -> writes to 1,2,3 in order, neurons_written=3.
REQ-038 add_done 0x00050000 and neuron_done in same cycle, acc previously 0x00010000 -> wr_data=0x0600; next neuron starts from acc=0.
REQ-039 Two add_done then rst for one cycle, then neuron_done -> one write of 0x0000; no earlier write appears.
